// File: rtl/store_buf_pkg.sv
// Shared size encodings and queue entry layout for the store buffer.
// Latency: n/a (types only). Backpressure: n/a.
package store_buf_pkg;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } entry_t;

endpackage

// File: rtl/store_lane_align.sv
// Formats sb/sh/sw data into replicated byte lanes with byte enables and flags odd cases.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module store_lane_align
    import store_buf_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        is_misaligned,
    output logic        is_reserved
);

    always_comb begin
        wdata         = '0;
        be            = '0;
        is_misaligned = 1'b0;
        is_reserved   = 1'b0;
        case (size)
            SZ_B: begin
                wdata = {4{data[7:0]}};
                be    = 4'b0001 << addr_lo;
            end
            SZ_H: begin
                wdata         = {2{data[15:0]}};
                be            = addr_lo[1] ? 4'b1100 : 4'b0011;
                is_misaligned = addr_lo[0];
            end
            SZ_W: begin
                wdata         = data;
                be            = 4'b1111;
                is_misaligned = (addr_lo != 2'b00);
            end
            default: is_reserved = 1'b1;
        endcase
    end

endmodule

// File: rtl/m_store_buffer.sv
// Store buffer: lane-formats M-stage stores and drains them in order to the DM write port.
// Latency: push in cycle N is visible on mem_req in N+1 at the earliest, no bypass.
// Backpressure: st_ready drops when DEPTH entries are queued (registered count only);
// STORE_BUF_MISALIGN_EXC_EN drops misaligned stores and pulses misalign.
module m_store_buffer
    import store_buf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [1:0]       st_size,
    output logic             mem_req,
    input  logic             mem_ack,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    output logic             empty,
    output logic [CNT_W-1:0] count
`ifdef STORE_BUF_MISALIGN_EXC_EN
   ,output logic             misalign
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    entry_t             q [DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        lane_wdata;
    logic [3:0]         lane_be;
    logic               lane_mis;
    logic               lane_rsv;
    logic               push;
    logic               pop;
    logic               enq;
    logic               drop_mis;

    store_lane_align u_align (
        .addr_lo       (st_addr[1:0]),
        .size          (st_size),
        .data          (st_data),
        .wdata         (lane_wdata),
        .be            (lane_be),
        .is_misaligned (lane_mis),
        .is_reserved   (lane_rsv)
    );

`ifdef STORE_BUF_MISALIGN_EXC_EN
    assign drop_mis = lane_mis;
`else
    logic unused_lane_mis;
    assign unused_lane_mis = lane_mis;
    assign drop_mis        = 1'b0;
`endif

    assign st_ready = (cnt != CNT_W'(DEPTH));
    assign push     = st_valid && st_ready;
    assign empty    = (cnt == '0);
    assign mem_req  = !empty;
    assign pop      = mem_req && mem_ack;
    // Reserved and (optionally) misaligned stores complete the handshake but leave no entry.
    assign enq      = push && !lane_rsv && !drop_mis;
    assign count    = cnt;

    assign head      = q[rd_ptr];
    assign mem_addr  = empty ? '0 : {head.addr, 2'b00};
    assign mem_wdata = empty ? '0 : head.wdata;
    assign mem_be    = empty ? '0 : head.be;

    always_ff @(posedge clk) begin
        if (enq) begin
            q[wr_ptr] <= '{addr: st_addr[31:2], wdata: lane_wdata, be: lane_be};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({enq, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef STORE_BUF_MISALIGN_EXC_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) misalign <= 1'b0;
        else       misalign <= push && lane_mis;
    end
`endif

endmodule

// File: tb/tb_m_store_buffer.sv
// Self-checking bench for m_store_buffer: lane vector table, hand sequences, random run vs queue model.
module tb_m_store_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             st_valid;
    logic             st_ready;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic [1:0]       st_size;
    logic             mem_req;
    logic             mem_ack;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_be;
    logic             empty;
    logic [CNT_W-1:0] count;
`ifdef STORE_BUF_MISALIGN_EXC_EN
    logic             misalign;
`endif

    always #5 clk = ~clk;

    m_store_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_size   (st_size),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .empty     (empty),
        .count     (count)
`ifdef STORE_BUF_MISALIGN_EXC_EN
       ,.misalign  (misalign)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
    } vec_t;

    exp_t mq[$];
    bit   exp_mis = 1'b0;
    int   nchk = 0;
    int   nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference formatting from lane geometry: an n-byte store covers the aligned n-byte
    // group holding addr, and lane i carries source byte (i mod n).
    function automatic bit model_fmt(input logic [31:0] a, input logic [31:0] d,
                                     input logic [1:0] sz, output exp_t e, output bit mis);
        int n;
        int base;
        e.addr  = {a[31:2], 2'b00};
        e.wdata = '0;
        e.be    = '0;
        mis     = 1'b0;
        if (sz == 2'b11) return 1'b0;
        n    = 1 << sz;
        base = (int'(a[1:0]) / n) * n;
        mis  = (int'(a[1:0]) % n) != 0;
        for (int i = 0; i < 4; i++) begin
            e.wdata[8*i +: 8] = d[8*(i % n) +: 8];
            e.be[i]           = (i >= base) && (i < base + n);
        end
`ifdef STORE_BUF_MISALIGN_EXC_EN
        if (mis) return 1'b0;
`endif
        return 1'b1;
    endfunction

    task automatic compare_model();
        bit has;
        has = mq.size() > 0;
        chk("st_ready", 32'(st_ready), 32'(mq.size() < DEPTH));
        chk("mem_req", 32'(mem_req), 32'(has));
        chk("empty", 32'(empty), 32'(!has));
        chk("count", 32'(count), 32'(mq.size()));
        chk("mem_addr", mem_addr, has ? mq[0].addr : 32'd0);
        chk("mem_wdata", mem_wdata, has ? mq[0].wdata : 32'd0);
        chk("mem_be", 32'(mem_be), has ? 32'(mq[0].be) : 32'd0);
`ifdef STORE_BUF_MISALIGN_EXC_EN
        chk("misalign", 32'(misalign), 32'(exp_mis));
`endif
    endtask

    // One clock: drive at posedge+1, compare at negedge, advance model after the edge.
    task automatic cycle(input bit v, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input bit ack);
        exp_t e;
        bit   ok;
        bit   mis;
        bit   push;
        bit   pop;
        st_valid = v;
        st_addr  = a;
        st_data  = d;
        st_size  = sz;
        mem_ack  = ack;
        @(negedge clk);
        compare_model();
        push = v && (mq.size() < DEPTH);
        pop  = ack && (mq.size() > 0);
        ok   = model_fmt(a, d, sz, e, mis);
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (push && ok) mq.push_back(e);
        exp_mis = push && mis;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 32'd0, 32'd0, 2'b00, 1'b1);
        chk("drain_empty", 32'(empty), 32'd1);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{32'h0000_1003, 32'h1234_56AB, 2'b00, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000};
        vecs[1] = '{32'h0000_2002, 32'hFFFF_BEEF, 2'b01, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100};
        vecs[2] = '{32'h0000_2004, 32'hCAFE_F00D, 2'b10, 32'h0000_2004, 32'hCAFE_F00D, 4'b1111};
        vecs[3] = '{32'h0000_0010, 32'h0000_005A, 2'b00, 32'h0000_0010, 32'h5A5A_5A5A, 4'b0001};
        vecs[4] = '{32'h8000_0011, 32'hFFFF_FF77, 2'b00, 32'h8000_0010, 32'h7777_7777, 4'b0010};
        vecs[5] = '{32'h0000_4000, 32'h1234_A55A, 2'b01, 32'h0000_4000, 32'hA55A_A55A, 4'b0011};

        reset    = 1'b1;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_size  = '0;
        mem_ack  = 1'b0;
        #2;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_st_ready", 32'(st_ready), 32'd1);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Lane formatting: push into empty queue with mem_ack already high, then drain.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, vecs[i].addr, vecs[i].data, vecs[i].size, 1'b1);
            chk("vec_mem_req", 32'(mem_req), 32'd1);
            chk("vec_mem_addr", mem_addr, vecs[i].exp_addr);
            chk("vec_mem_wdata", mem_wdata, vecs[i].exp_wdata);
            chk("vec_mem_be", 32'(mem_be), 32'(vecs[i].exp_be));
            cycle(1'b0, 32'd0, 32'd0, 2'b00, 1'b1);
            chk("vec_empty_after", 32'(empty), 32'd1);
        end

        // Ordered half then word with held ack.
        cycle(1'b1, 32'h0000_2002, 32'hFFFF_BEEF, 2'b01, 1'b0);
        cycle(1'b1, 32'h0000_2004, 32'hCAFE_F00D, 2'b10, 1'b0);
        chk("hw_count", 32'(count), 32'd2);
        chk("hw_head_be", 32'(mem_be), 32'h0000_000C);
        cycle(1'b0, 32'd0, 32'd0, 2'b00, 1'b1);
        chk("hw_second_addr", mem_addr, 32'h0000_2004);
        chk("hw_second_be", 32'(mem_be), 32'h0000_000F);
        drain();

        // Reserved size: handshake completes, nothing queued.
        cycle(1'b1, 32'h0000_5000, 32'hDEAD_BEEF, 2'b11, 1'b0);
        chk("rsv_empty", 32'(empty), 32'd1);

        // Misaligned word.
        cycle(1'b1, 32'h0000_3001, 32'h1111_2222, 2'b10, 1'b0);
`ifdef STORE_BUF_MISALIGN_EXC_EN
        chk("mis_pulse", 32'(misalign), 32'd1);
        chk("mis_count", 32'(count), 32'd0);
        cycle(1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
        chk("mis_pulse_end", 32'(misalign), 32'd0);
`else
        chk("mis_count", 32'(count), 32'd1);
        chk("mis_addr", mem_addr, 32'h0000_3000);
        chk("mis_be", 32'(mem_be), 32'h0000_000F);
`endif
        drain();

        // Backpressure: five word stores offered with ack low.
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 32'h0000_0100 + 32'(4*i), 32'hA000_0000 + 32'(i), 2'b10, 1'b0);
        chk("bp_st_ready", 32'(st_ready), 32'd0);
        chk("bp_count", 32'(count), 32'd4);
        chk("bp_head_addr", mem_addr, 32'h0000_0100);
        cycle(1'b1, 32'h0000_0110, 32'hA000_0004, 2'b10, 1'b1);
        chk("bp_full_pop_count", 32'(count), 32'd3);
        chk("bp_next_head", mem_addr, 32'h0000_0104);
        cycle(1'b1, 32'h0000_0110, 32'hA000_0004, 2'b10, 1'b1);
        chk("bp_fifth_in_count", 32'(count), 32'd3);
        drain();

        // Simultaneous push/pop at count 2 across pointer wrap.
        cycle(1'b1, 32'h0000_0600, 32'h6000_0000, 2'b10, 1'b0);
        cycle(1'b1, 32'h0000_0604, 32'h6000_0001, 2'b10, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'h0000_0608 + 32'(4*i), $urandom, 2'b10, 1'b1);
            chk("pp_count", 32'(count), 32'd2);
        end
        drain();

        // Reset between edges while draining.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h0000_0700 + 32'(4*i), 32'h7000_0000 + 32'(i), 2'b10, 1'b0);
        chk("rmd_count", 32'(count), 32'd3);
        mem_ack  = 1'b1;
        st_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rmd_mem_req", 32'(mem_req), 32'd0);
        chk("rmd_count0", 32'(count), 32'd0);
        chk("rmd_empty", 32'(empty), 32'd1);
        chk("rmd_mem_addr", mem_addr, 32'd0);
        mq.delete();
        exp_mis = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(1'b1, 32'h0000_7002, 32'h0000_00C3, 2'b00, 1'b0);
        chk("rmd_only_addr", mem_addr, 32'h0000_7000);
        chk("rmd_only_wdata", mem_wdata, 32'hC3C3_C3C3);
        cycle(1'b0, 32'd0, 32'd0, 2'b00, 1'b1);
        chk("rmd_only_empty", 32'(empty), 32'd1);

        // Random traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom,
                  2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
